// File: rtl/fp16_align_add_if.sv
// Handshake and data bundle between the FP16 align-add stage and its neighbours.
// master: operand source / result sink side; slave: the align-add stage.
interface fp16_align_add_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    logic                 in_valid;
    logic                 in_ready;
    logic [EXP_W+MAN_W:0] op_a;
    logic [EXP_W+MAN_W:0] op_b;
    logic                 sub;
    logic                 out_valid;
    logic                 out_ready;
    logic                 sign_res;
    logic [MAN_W+1:0]     bigsum12;
    logic [EXP_W-1:0]     exponent_res;

    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, sign_res, bigsum12, exponent_res
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, sign_res, bigsum12, exponent_res
    );
endinterface

// File: rtl/fp16_align_add.sv
// Pre-normalization add stage of the FP16 MAC: unpack, order by magnitude,
// serially align the smaller significand (one bit per cycle), then add or
// subtract and hold {sign, raw sum, big exponent} until the normalizer takes it.
//
// state | meaning
// IDLE  | ready for an operand pair
// ALIGN | shifting the small significand right, then forming the sum
// DONE  | result presented, waiting for out_ready
module fp16_align_add #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    fp16_align_add_if.slave  bus
);
    localparam int OP_W  = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;
    localparam int SUM_W = MAN_W + 2;
    localparam int CNT_W = $clog2(MAN_W + 2);
    localparam logic [EXP_W-1:0] MAX_SH = EXP_W'(MAN_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_load;
    logic                w_shift;
    logic                w_finish;

    logic [SIG_W-1:0]    r_big;
    logic [SIG_W-1:0]    r_small;
    logic                r_sign_big;
    logic                r_eff_sub;
    logic [EXP_W-1:0]    r_exp_big;
    logic [CNT_W-1:0]    r_count;
    logic                r_sign_res;
    logic [SUM_W-1:0]    r_sum;
    logic [EXP_W-1:0]    r_exp_res;

    // Unpacked operands; exp==0 flushes the significand (zero and denormals alike).
    logic                w_sign_a, w_sign_b;
    logic [EXP_W-1:0]    w_exp_a, w_exp_b;
    logic [MAN_W-1:0]    w_man_a, w_man_b;
    logic [SIG_W-1:0]    w_sig_a, w_sig_b;
    logic                w_a_big;
    logic [EXP_W-1:0]    w_exp_diff;
    logic [EXP_W-1:0]    w_diff_clamp;
    logic [CNT_W-1:0]    w_count_ld;
    logic [SUM_W-1:0]    w_sum;

    assign w_sign_a = bus.op_a[OP_W-1];
    assign w_exp_a  = bus.op_a[OP_W-2 -: EXP_W];
    assign w_man_a  = bus.op_a[MAN_W-1:0];
    assign w_sign_b = bus.op_b[OP_W-1] ^ bus.sub;
    assign w_exp_b  = bus.op_b[OP_W-2 -: EXP_W];
    assign w_man_b  = bus.op_b[MAN_W-1:0];

    assign w_sig_a = (w_exp_a != '0) ? {1'b1, w_man_a} : '0;
    assign w_sig_b = (w_exp_b != '0) ? {1'b1, w_man_b} : '0;

    // Magnitude ordering ignores sign; an exact tie keeps A as the big operand.
    assign w_a_big      = {w_exp_a, w_man_a} >= {w_exp_b, w_man_b};
    assign w_exp_diff   = w_a_big ? (w_exp_a - w_exp_b) : (w_exp_b - w_exp_a);
    // Beyond MAN_W+1 shifts the small significand is already all zero.
    assign w_diff_clamp = (w_exp_diff > MAX_SH) ? MAX_SH : w_exp_diff;
    assign w_count_ld   = CNT_W'(w_diff_clamp);

    // big >= small after alignment, so the difference never wraps.
    assign w_sum = r_eff_sub ? ({1'b0, r_big} - {1'b0, r_small})
                             : ({1'b0, r_big} + {1'b0, r_small});

    assign bus.in_ready     = (r_state == S_IDLE);
    assign bus.out_valid    = (r_state == S_DONE);
    assign bus.sign_res     = r_sign_res;
    assign bus.bigsum12     = r_sum;
    assign bus.exponent_res = r_exp_res;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath control strobes.
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_load = 1'b1;
                    w_next = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (r_count != '0) begin
                    w_shift = 1'b1;
                end else begin
                    w_finish = 1'b1;
                    w_next   = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, serial alignment and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_big      <= '0;
            r_small    <= '0;
            r_sign_big <= 1'b0;
            r_eff_sub  <= 1'b0;
            r_exp_big  <= '0;
            r_count    <= '0;
            r_sign_res <= 1'b0;
            r_sum      <= '0;
            r_exp_res  <= '0;
        end else begin
            if (w_load) begin
                r_big      <= w_a_big ? w_sig_a : w_sig_b;
                r_small    <= w_a_big ? w_sig_b : w_sig_a;
                r_sign_big <= w_a_big ? w_sign_a : w_sign_b;
                r_exp_big  <= w_a_big ? w_exp_a : w_exp_b;
                r_eff_sub  <= w_sign_a ^ w_sign_b;
                r_count    <= w_count_ld;
            end
            if (w_shift) begin
                r_small <= r_small >> 1;
                r_count <= r_count - 1'b1;
            end
            if (w_finish) begin
                r_sum      <= w_sum;
                r_sign_res <= (w_sum == '0) ? 1'b0 : r_sign_big;
                r_exp_res  <= r_exp_big;
            end
        end
    end
endmodule
